// File: rtl/fetch_stage_if.sv
// Fetch-stage signal bundle: instruction bus request/response, redirect
// from execute, and the if_id payload handshake towards decode.
interface fetch_stage_if #(
  parameter int unsigned XLEN = 64
);
  logic            ireq_valid;
  logic [XLEN-1:0] ireq_addr;
  logic            iresp_data_ok;
  logic [31:0]     iresp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            out_valid;
  logic [31:0]     out_instr;
  logic [XLEN-1:0] out_pc;
  logic            out_ready;

  // Fetch stage side
  modport master (
    output ireq_valid, ireq_addr, out_valid, out_instr, out_pc,
    input  iresp_data_ok, iresp_data, redirect_valid, redirect_pc, out_ready
  );

  // Environment side: bus, execute and decode
  modport slave (
    input  ireq_valid, ireq_addr, out_valid, out_instr, out_pc,
    output iresp_data_ok, iresp_data, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, keeps one request outstanding on the
// instruction bus, buffers returned words with their PC in a small FIFO and
// hands them to decode. Redirects flush the FIFO and restart fetch.
module fetch_stage #(
  parameter int unsigned            XLEN       = 64,
  parameter logic [XLEN-1:0]        RESET_PC   = 64'h8000_0000,
  parameter int unsigned            FIFO_DEPTH = 2
) (
  input logic          clk,
  input logic          reset,
  fetch_stage_if.master bus
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_C  = PW'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_addr_q, req_addr_d;
  logic [CW-1:0]   count_q;
  logic [PW-1:0]   head_q, tail_q;
  logic [31:0]     instr_mem [FIFO_DEPTH];
  logic [XLEN-1:0] pc_mem    [FIFO_DEPTH];

  logic            push, pop, flush;
  logic [XLEN-1:0] redir_pc;
  logic [XLEN-1:0] req_next;
  logic [CW-1:0]   count_after;

  // Every redirect flushes, whatever the state; flush outranks pop and push.
  assign flush       = bus.redirect_valid;
  assign pop         = bus.out_valid && bus.out_ready && !flush;
  assign redir_pc    = {bus.redirect_pc[XLEN-1:2], 2'b00};
  assign req_next    = req_addr_q + XLEN'(4);
  // Only used on a push from REQ, where a free slot was reserved, so no overflow.
  assign count_after = count_q + CW'(1) - CW'(pop);

  assign bus.ireq_valid = (state_q == REQ) || (state_q == DISCARD);
  assign bus.ireq_addr  = req_addr_q;
  assign bus.out_valid  = (count_q != '0);
  assign bus.out_instr  = bus.out_valid ? instr_mem[head_q] : '0;
  assign bus.out_pc     = bus.out_valid ? pc_mem[head_q]    : '0;

  // Next-state, PC and request-address selection.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    push       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.redirect_valid) begin
          pc_d       = redir_pc;
          req_addr_d = redir_pc;
          state_d    = REQ;
        end else if (count_q < DEPTH_C) begin
          req_addr_d = pc_q;
          state_d    = REQ;
        end
      end
      REQ: begin
        if (bus.redirect_valid) begin
          pc_d = redir_pc;
          if (bus.iresp_data_ok) begin
            req_addr_d = redir_pc;
          end else begin
            state_d = DISCARD;
          end
        end else if (bus.iresp_data_ok) begin
          push = 1'b1;
          pc_d = req_next;
          if (count_after < DEPTH_C) begin
            req_addr_d = req_next;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DISCARD: begin
        if (bus.redirect_valid) begin
          pc_d = redir_pc;
          if (bus.iresp_data_ok) begin
            req_addr_d = redir_pc;
            state_d    = REQ;
          end
        end else if (bus.iresp_data_ok) begin
          req_addr_d = pc_q;
          state_d    = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM, PC and request-address registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        tail_q <= (tail_q == LAST_C) ? '0 : tail_q + PW'(1);
      end
      if (pop) begin
        head_q <= (head_q == LAST_C) ? '0 : head_q + PW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // FIFO storage; empty-slot contents are masked at the output.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[tail_q] <= bus.iresp_data;
      pc_mem[tail_q]    <= req_addr_q;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: an instruction-memory responder with a response
// budget, directed redirect/reset scenarios, and a scoreboard monitor that
// compares every word accepted by decode against the expected PC stream.
module tb_fetch_stage;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic clk;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   budget  = 0;
  exp_t exp_q[$];

  fetch_stage_if #(.XLEN(64)) bus ();

  fetch_stage #(
    .XLEN      (64),
    .RESET_PC  (64'h8000_0000),
    .FIFO_DEPTH(2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] instr_of(input logic [63:0] a);
    instr_of = a[31:0] ^ 32'hA5A5_0013;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic push_exp(input logic [63:0] pc);
    exp_t e;
    e.pc    = pc;
    e.instr = instr_of(pc);
    exp_q.push_back(e);
  endtask

  // One clock; then act as memory for whatever request is held, within budget.
  task automatic step();
    @(posedge clk);
    #1;
    if (budget > 0 && bus.ireq_valid) begin
      bus.iresp_data_ok = 1'b1;
      bus.iresp_data    = instr_of(bus.ireq_addr);
      budget--;
    end else begin
      bus.iresp_data_ok = 1'b0;
      bus.iresp_data    = 32'hDEAD_BEEF;
    end
  endtask

  task automatic do_reset();
    budget             = 0;
    reset              = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.out_ready      = 1'b0;
    step();
    step();
    exp_q.delete();
    reset = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    int unsigned n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      step();
      n++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  // Scoreboard monitor: every handshake with decode must match the queue head.
  always @(negedge clk) begin
    if (reset && bus.out_valid && bus.out_ready) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got pc %h instr %h expected no output", bus.out_pc, bus.out_instr);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (bus.out_pc !== e.pc || bus.out_instr !== e.instr) begin
          n_fail++;
          $display("FAIL sb_payload: got pc %h instr %h expected pc %h instr %h",
                   bus.out_pc, bus.out_instr, e.pc, e.instr);
        end
      end
    end
  end

  initial begin
    reset              = 1'b0;
    bus.iresp_data_ok  = 1'b0;
    bus.iresp_data     = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.out_ready      = 1'b0;

    // Reset state
    do_reset();
    check("rst_ireq_valid", 64'(bus.ireq_valid), 64'd0);
    check("rst_ireq_addr", bus.ireq_addr, 64'h8000_0000);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_instr", 64'(bus.out_instr), 64'd0);
    check("rst_out_pc", bus.out_pc, 64'd0);

    // 1: streaming, one instruction per cycle without gaps
    do_reset();
    for (int i = 0; i < 8; i++) push_exp(64'h8000_0000 + 64'(4 * i));
    bus.out_ready = 1'b1;
    budget = 8;
    step();
    step();
    for (int i = 0; i < 8; i++) begin
      check("t1_no_gap", 64'(bus.out_valid), 64'd1);
      step();
    end
    check("t1_drained", 64'(exp_q.size()), 64'd0);
    check("t1_next_addr", bus.ireq_addr, 64'h8000_0020);

    // 2: backpressure fills the FIFO and parks the fetcher
    do_reset();
    push_exp(64'h8000_0000);
    push_exp(64'h8000_0004);
    budget = 2;
    step();
    step();
    step();
    check("t2_idle_full", 64'(bus.ireq_valid), 64'd0);
    check("t2_head_pc", bus.out_pc, 64'h8000_0000);
    step();
    step();
    check("t2_still_idle", 64'(bus.ireq_valid), 64'd0);
    check("t2_head_held", bus.out_pc, 64'h8000_0000);
    bus.out_ready = 1'b1;
    step();
    step();
    check("t2_drained", 64'(exp_q.size()), 64'd0);
    check("t2_req_valid", 64'(bus.ireq_valid), 64'd1);
    check("t2_req_addr", bus.ireq_addr, 64'h8000_0008);

    // 3: redirect while a request is outstanding without data
    do_reset();
    budget = 1;
    step();
    step();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h8000_1000;
    step();
    bus.redirect_valid = 1'b0;
    check("t3_flushed", 64'(bus.out_valid), 64'd0);
    check("t3_discard_valid", 64'(bus.ireq_valid), 64'd1);
    check("t3_discard_addr", bus.ireq_addr, 64'h8000_0004);
    step();
    step();
    step();
    check("t3_addr_stable", bus.ireq_addr, 64'h8000_0004);
    push_exp(64'h8000_1000);
    push_exp(64'h8000_1004);
    bus.out_ready = 1'b1;
    budget = 3;
    wait_drain("t3_drain");
    check("t3_next_addr", bus.ireq_addr, 64'h8000_1008);

    // 4: redirect in the same cycle as data_ok
    do_reset();
    bus.out_ready = 1'b1;
    budget = 1;
    step();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h8000_1000;
    step();
    bus.redirect_valid = 1'b0;
    check("t4_empty", 64'(bus.out_valid), 64'd0);
    check("t4_req_valid", 64'(bus.ireq_valid), 64'd1);
    check("t4_req_addr", bus.ireq_addr, 64'h8000_1000);
    push_exp(64'h8000_1000);
    budget = 1;
    wait_drain("t4_drain");

    // 5: reset while discarding
    do_reset();
    budget = 1;
    step();
    step();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h8000_1000;
    step();
    bus.redirect_valid = 1'b0;
    check("t5_in_discard", 64'(bus.ireq_valid), 64'd1);
    reset = 1'b0;
    step();
    check("t5_rst_ireq", 64'(bus.ireq_valid), 64'd0);
    check("t5_rst_out", 64'(bus.out_valid), 64'd0);
    reset = 1'b1;
    step();
    check("t5_restart_valid", 64'(bus.ireq_valid), 64'd1);
    check("t5_restart_addr", bus.ireq_addr, 64'h8000_0000);

    // 6: misaligned redirect target and PC wrap at the top of the space
    do_reset();
    bus.out_ready = 1'b1;
    step();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h8000_1002;
    step();
    bus.redirect_valid = 1'b0;
    push_exp(64'h8000_1000);
    budget = 2;
    wait_drain("t6_align_drain");
    check("t6_after_align", bus.ireq_addr, 64'h8000_1004);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    bus.redirect_valid = 1'b0;
    push_exp(64'hFFFF_FFFF_FFFF_FFFC);
    budget = 2;
    wait_drain("t6_top_drain");
    check("t6_wrap_valid", 64'(bus.ireq_valid), 64'd1);
    check("t6_wrap_addr", bus.ireq_addr, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
